// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      STALL = 2'd2
   } fetch_state_e;

   // One instruction word is four bytes; pc advances by this amount.
   localparam int PC_INC = 4;

   // Byte-address width for a word-addressed memory of the given depth.
   function automatic int byte_addr_w(input int depth_words);
      return $clog2(depth_words) + 2;
   endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating fetch / bubble event counters for fetch_ctrl.
// Only present when FETCH_CTRL_PERF_CNT_EN is defined.
`ifdef FETCH_CTRL_PERF_CNT_EN
module fetch_perf_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        fetch_inc,
   input  logic        bubble_inc,
   output logic [31:0] fetch_cnt,
   output logic [31:0] bubble_cnt
);

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Counters clear on reset or clr; otherwise count their events.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         fetch_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (fetch_inc)  fetch_cnt  <= sat_inc(fetch_cnt);
         if (bubble_inc) bubble_cnt <= sat_inc(bubble_cnt);
      end
   end

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the pc, arbitrates the single-port
// instruction memory between the loader and fetch, applies stall and
// branch redirect, and flags valid fetched words for decode.
// Optional macro FETCH_CTRL_PERF_CNT_EN adds perf counters and perf_clr.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter  int INST_MEM_DEPTH  = 32,
   parameter  int INST_MEM_DAT_W  = 32,
   parameter  int RST_PC          = 0,
   localparam int INST_MEM_ADDR_W = byte_addr_w(INST_MEM_DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       run,
   input  logic                       halt,
   input  logic                       stall,
   input  logic                       redir_vld,
   input  logic [INST_MEM_ADDR_W-1:0] redir_pc,
   input  logic                       ld_req,
   input  logic [INST_MEM_ADDR_W-1:0] ld_addr,
   input  logic [INST_MEM_DAT_W-1:0]  ld_dat,
   output logic                       ld_gnt,
   output logic [INST_MEM_ADDR_W-1:0] pc,
   output logic                       mem_we,
   output logic [INST_MEM_ADDR_W-1:0] mem_addr,
   output logic [INST_MEM_DAT_W-1:0]  mem_dat,
   output logic                       id_vld,
   output logic                       busy
`ifdef FETCH_CTRL_PERF_CNT_EN
   ,
   input  logic                       perf_clr,
   output logic [31:0]                perf_fetch_cnt,
   output logic [31:0]                perf_bubble_cnt
`endif
);

   localparam logic [INST_MEM_ADDR_W-1:0] WORD_MASK = ~INST_MEM_ADDR_W'(3);
   localparam logic [INST_MEM_ADDR_W-1:0] PC_STEP   = INST_MEM_ADDR_W'(PC_INC);
   localparam logic [INST_MEM_ADDR_W-1:0] PC_RESET  = INST_MEM_ADDR_W'(RST_PC);

   fetch_state_e                 state_r, state_nxt;
   logic [INST_MEM_ADDR_W-1:0]   pc_r, pc_nxt;
   logic                         id_vld_p1, id_vld_nxt;
   logic                         fetch_issue;

   // Memory port: the loader always wins; otherwise the port reads at pc.
   always_comb begin
      ld_gnt   = ld_req;
      mem_we   = ld_req;
      mem_addr = ld_req ? (ld_addr & WORD_MASK) : pc_r;
      mem_dat  = ld_dat;
      pc       = pc_r;
      id_vld   = id_vld_p1;
      busy     = (state_r != IDLE);
   end

   // Next state, next pc and fetch issue; priority halt > redirect > loader > stall > sequential.
   always_comb begin
      state_nxt   = state_r;
      pc_nxt      = pc_r;
      id_vld_nxt  = id_vld_p1;
      fetch_issue = 1'b0;
      unique case (state_r)
         IDLE: begin
            id_vld_nxt = 1'b0;
            if (halt) begin
               pc_nxt = PC_RESET;
            end else if (run && !ld_req) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (halt) begin
               state_nxt  = IDLE;
               pc_nxt     = PC_RESET;
               id_vld_nxt = 1'b0;
            end else if (redir_vld) begin
               pc_nxt     = redir_pc & WORD_MASK;
               id_vld_nxt = 1'b0;
            end else if (!run) begin
               state_nxt  = IDLE;
               id_vld_nxt = 1'b0;
            end else if (ld_req) begin
               // Port taken by the loader: pc held, bubble into decode.
               state_nxt  = stall ? STALL : FETCH;
               id_vld_nxt = 1'b0;
            end else if (stall) begin
               // Decode refused the presented word; keep it flagged valid.
               state_nxt = STALL;
            end else begin
               fetch_issue = 1'b1;
            end
         end
         STALL: begin
            if (halt) begin
               state_nxt  = IDLE;
               pc_nxt     = PC_RESET;
               id_vld_nxt = 1'b0;
            end else if (redir_vld) begin
               // Redirect beats stall and squashes the held word.
               state_nxt  = FETCH;
               pc_nxt     = redir_pc & WORD_MASK;
               id_vld_nxt = 1'b0;
            end else if (!stall) begin
               // Held word is consumed this cycle; nothing new was issued.
               state_nxt  = FETCH;
               id_vld_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt  = IDLE;
            id_vld_nxt = 1'b0;
         end
      endcase
      if (fetch_issue) begin
         pc_nxt     = pc_r + PC_STEP;
         id_vld_nxt = 1'b1;
      end
   end

   // State, pc and the registered fetch-issue flag (read data valid next cycle).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         pc_r      <= PC_RESET;
         id_vld_p1 <= 1'b0;
      end else begin
         state_r   <= state_nxt;
         pc_r      <= pc_nxt;
         id_vld_p1 <= id_vld_nxt;
      end
   end

`ifdef FETCH_CTRL_PERF_CNT_EN
   logic bubble_inc;

   // A bubble is any active cycle that issued no fetch.
   always_comb begin
      bubble_inc = (state_r != IDLE) && !fetch_issue;
   end

   fetch_perf_cnt u_perf (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (perf_clr),
      .fetch_inc  (fetch_issue),
      .bubble_inc (bubble_inc),
      .fetch_cnt  (perf_fetch_cnt),
      .bubble_cnt (perf_bubble_cnt)
   );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (default parameters).
module tb_fetch_ctrl;

   localparam int AW = 7;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n, run, halt, stall, redir_vld, ld_req;
   logic [AW-1:0] redir_pc, ld_addr;
   logic [DW-1:0] ld_dat;
   logic          ld_gnt, mem_we, id_vld, busy;
   logic [AW-1:0] pc, mem_addr;
   logic [DW-1:0] mem_dat;
`ifdef FETCH_CTRL_PERF_CNT_EN
   logic          perf_clr;
   logic [31:0]   perf_fetch_cnt, perf_bubble_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   fetch_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .halt      (halt),
      .stall     (stall),
      .redir_vld (redir_vld),
      .redir_pc  (redir_pc),
      .ld_req    (ld_req),
      .ld_addr   (ld_addr),
      .ld_dat    (ld_dat),
      .ld_gnt    (ld_gnt),
      .pc        (pc),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_dat   (mem_dat),
      .id_vld    (id_vld),
      .busy      (busy)
`ifdef FETCH_CTRL_PERF_CNT_EN
      ,
      .perf_clr        (perf_clr),
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_bubble_cnt (perf_bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; halt = 1'b0; stall = 1'b0;
      redir_vld = 1'b0; redir_pc = '0; ld_req = 1'b0; ld_addr = '0; ld_dat = '0;
`ifdef FETCH_CTRL_PERF_CNT_EN
      perf_clr = 1'b0;
`endif
      tick; tick; #1;
      check("rst_pc",   32'(pc), 32'h0);
      check("rst_vld",  32'(id_vld), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_we",   32'(mem_we), 32'h0);
      check("rst_gnt",  32'(ld_gnt), 32'h0);
      check("rst_addr", 32'(mem_addr), 32'h0);

      // Sequential fetch from RST_PC through the top of memory and wrap.
      rst_n = 1'b1; run = 1'b1; #1;
      check("idle_busy", 32'(busy), 32'h0);
      tick; #1;
      check("f0_busy", 32'(busy), 32'h1);
      check("f0_addr", 32'(mem_addr), 32'h0);
      check("f0_vld",  32'(id_vld), 32'h0);
      for (int i = 1; i < 32; i++) begin
         tick; #1;
         check("seq_addr", 32'(mem_addr), 32'(4 * i));
         check("seq_vld",  32'(id_vld), 32'h1);
      end
      tick; #1;
      check("wrap_pc",  32'(pc), 32'h0);
      check("wrap_vld", 32'(id_vld), 32'h1);

      // Loader write at pc=0x08: port stolen, pc held, bubble.
      tick; tick; #1;
      check("pre_ld_pc", 32'(pc), 32'h08);
      ld_req = 1'b1; ld_addr = 7'h13; ld_dat = 32'hDEAD_BEEF; #1;
      check("ld_gnt",  32'(ld_gnt), 32'h1);
      check("ld_we",   32'(mem_we), 32'h1);
      check("ld_addr", 32'(mem_addr), 32'h10);
      check("ld_dat",  mem_dat, 32'hDEAD_BEEF);
      tick; ld_req = 1'b0; #1;
      check("ldb_pc",  32'(pc), 32'h08);
      check("ldb_vld", 32'(id_vld), 32'h0);
      check("ldb_we",  32'(mem_we), 32'h0);
      tick; #1;
      check("post_ld_pc",  32'(pc), 32'h0C);
      check("post_ld_vld", 32'(id_vld), 32'h1);

      // Stall for 3 cycles at pc=0x0C: pc and id_vld held.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick; #1;
         check("stl_pc",   32'(pc), 32'h0C);
         check("stl_vld",  32'(id_vld), 32'h1);
         check("stl_busy", 32'(busy), 32'h1);
      end
      stall = 1'b0;
      tick; #1;
      check("rel_pc",   32'(pc), 32'h0C);
      check("rel_vld",  32'(id_vld), 32'h0);
      check("rel_addr", 32'(mem_addr), 32'h0C);
      tick; #1;
      check("res_pc",  32'(pc), 32'h10);
      check("res_vld", 32'(id_vld), 32'h1);

      // Redirect to 0x23 while stalled: aligned target, squash, FETCH.
      stall = 1'b1;
      tick;
      redir_vld = 1'b1; redir_pc = 7'h23;
      tick;
      redir_vld = 1'b0; stall = 1'b0; #1;
      check("rd_pc",   32'(pc), 32'h20);
      check("rd_vld",  32'(id_vld), 32'h0);
      check("rd_addr", 32'(mem_addr), 32'h20);
      tick; #1;
      check("rd_pc2",  32'(pc), 32'h24);
      check("rd_vld2", 32'(id_vld), 32'h1);

      // Halt at pc=0x40, then restart from RST_PC with run still high.
      for (int i = 0; i < 7; i++) tick;
      #1;
      check("pre_hlt_pc", 32'(pc), 32'h40);
      halt = 1'b1;
      tick;
      halt = 1'b0; #1;
      check("hlt_pc",   32'(pc), 32'h0);
      check("hlt_vld",  32'(id_vld), 32'h0);
      check("hlt_busy", 32'(busy), 32'h0);
      tick; #1;
      check("rst_fetch_busy", 32'(busy), 32'h1);
      check("rst_fetch_addr", 32'(mem_addr), 32'h0);
      tick; #1;
      check("rst_fetch_pc",  32'(pc), 32'h4);
      check("rst_fetch_vld", 32'(id_vld), 32'h1);

      // Reset pulse mid-fetch discards all state.
      tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1; #1;
      check("mid_rst_pc",   32'(pc), 32'h0);
      check("mid_rst_vld",  32'(id_vld), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
`ifdef FETCH_CTRL_PERF_CNT_EN
      check("mid_rst_fcnt", perf_fetch_cnt, 32'h0);
      check("mid_rst_bcnt", perf_bubble_cnt, 32'h0);
      tick; tick; tick; #1;
      check("perf_fcnt", perf_fetch_cnt, 32'h2);
      check("perf_bcnt", perf_bubble_cnt, 32'h0);
      perf_clr = 1'b1;
      tick;
      perf_clr = 1'b0; #1;
      check("perf_clr_fcnt", perf_fetch_cnt, 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
